// File: rtl/mac_vector_driver.sv
// Sequences one dot product through an external pipelined MAC: clears the
// accumulator, streams A[i]/B[i] pairs, then waits for every result strobe.
module mac_vector_driver #(
  parameter int VLEN    = 4,
  parameter int WIDTH   = 14,
  parameter int OWIDTH  = 28,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic                      wr_sel,
  input  logic [$clog2(VLEN)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      start,
  input  logic                      pause,
  output logic                      mac_rst,
  output logic                      mac_valid,
  output logic [WIDTH-1:0]          mac_a,
  output logic [WIDTH-1:0]          mac_b,
  input  logic [OWIDTH-1:0]         mac_f,
  input  logic                      mac_valid_out,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [OWIDTH-1:0]         result
);

  localparam int AW = $clog2(VLEN);
  localparam int RW = $clog2(VLEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [RW-1:0]     ret_q, ret_d;
  logic [TW-1:0]     drain_q, drain_d;
  logic [WIDTH-1:0]  hold_a_q, hold_a_d;
  logic [WIDTH-1:0]  hold_b_q, hold_b_d;
  logic              error_q, error_d;
  logic [OWIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]  buf_a_q [VLEN];
  logic [WIDTH-1:0]  buf_b_q [VLEN];

  logic              issue;
  logic              counting;
  logic              ret_hit;

  // Operand buffers carry no reset: contents are meaningless until rewritten.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == S_IDLE) && ({1'b0, wr_addr} < (AW + 1)'(VLEN))) begin
      if (wr_sel) begin
        buf_b_q[wr_addr] <= wr_data;
      end else begin
        buf_a_q[wr_addr] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      ret_q    <= '0;
      drain_q  <= '0;
      hold_a_q <= '0;
      hold_b_q <= '0;
      error_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ret_q    <= ret_d;
      drain_q  <= drain_d;
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
      error_q  <= error_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ret_d    = ret_q;
    drain_d  = drain_q;
    hold_a_d = hold_a_q;
    hold_b_d = hold_b_q;
    error_d  = error_q;
    result_d = result_q;

    issue    = (state_q == S_ISSUE) && !pause;
    counting = (state_q == S_CLEAR) || (state_q == S_ISSUE) || (state_q == S_DRAIN);
    ret_hit  = counting && mac_valid_out && (ret_q == RW'(VLEN - 1));

    // Return strobes are counted on their own, whatever the issue progress.
    if (counting && mac_valid_out) begin
      ret_d = ret_q + 1'b1;
    end

    if (issue) begin
      hold_a_d = buf_a_q[idx_q];
      hold_b_d = buf_b_q[idx_q];
      idx_d    = idx_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          idx_d   = '0;
          ret_d   = '0;
          error_d = 1'b0;
        end
      end
      S_CLEAR: begin
        state_d = S_ISSUE;
        drain_d = '0;
      end
      S_ISSUE: begin
        if (issue && (idx_q == AW'(VLEN - 1))) begin
          state_d = S_DRAIN;
          idx_d   = '0;
        end
      end
      S_DRAIN: begin
        if (!ret_hit) begin
          if (drain_q == TW'(TIMEOUT - 1)) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The final strobe wins over any other transition in the same cycle.
    if (ret_hit) begin
      result_d = mac_f;
      state_d  = S_DONE;
    end
  end

  assign mac_rst   = (state_q == S_CLEAR);
  assign mac_valid = issue;
  assign mac_a     = issue ? buf_a_q[idx_q] : hold_a_q;
  assign mac_b     = issue ? buf_b_q[idx_q] : hold_b_q;
  assign busy      = counting;
  assign done      = (state_q == S_DONE);
  assign error     = error_q;
  assign result    = result_q;

endmodule

// File: tb/tb_mac_vector_driver.sv
// Bench for mac_vector_driver with a 3-edge saturating MAC model attached;
// issued pairs and final results are checked against scoreboards.
module tb_mac_vector_driver;

  localparam int VLEN = 4;
  localparam int W    = 14;
  localparam int OW   = 28;
  localparam int TO   = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic          wr_sel = 1'b0;
  logic [1:0]    wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          mac_rst, mac_valid;
  logic [W-1:0]  mac_a, mac_b;
  logic [OW-1:0] mac_f;
  logic          mac_valid_out;
  logic          busy, done, error;
  logic [OW-1:0] result;

  mac_vector_driver #(.VLEN(VLEN), .WIDTH(W), .OWIDTH(OW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .pause(pause),
    .mac_rst(mac_rst), .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b),
    .mac_f(mac_f), .mac_valid_out(mac_valid_out),
    .busy(busy), .done(done), .error(error), .result(result)
  );

  always #5 clk = ~clk;

  // MAC model: product, pipeline, saturating accumulate; f and strobe together.
  logic                   mac_conn = 1'b1;
  logic                   m_v1 = 1'b0, m_v2 = 1'b0, m_vout = 1'b0;
  logic signed [2*W-1:0]  m_p1 = '0, m_p2 = '0;
  logic signed [OW-1:0]   m_acc = '0;

  function automatic logic signed [OW-1:0] sat(input logic signed [39:0] s);
    if (s > 40'sd134217727)       sat = 28'h7FFFFFF;
    else if (s < -40'sd134217728) sat = 28'h8000000;
    else                          sat = s[OW-1:0];
  endfunction

  always @(posedge clk) begin
    m_v1   <= mac_valid;
    m_p1   <= $signed(mac_a) * $signed(mac_b);
    m_v2   <= m_v1;
    m_p2   <= m_p1;
    m_vout <= m_v2;
    if (mac_rst)   m_acc <= '0;
    else if (m_v2) m_acc <= sat(40'(m_acc) + 40'(m_p2));
  end

  assign mac_f         = m_acc;
  assign mac_valid_out = m_vout & mac_conn;

  typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; } pair_t;
  typedef struct packed { logic [OW-1:0] res; logic err; } res_t;

  pair_t pair_q[$];
  res_t  res_q[$];
  logic signed [W-1:0] mdl_a [VLEN];
  logic signed [W-1:0] mdl_b [VLEN];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int nvalid = 0, nrst = 0, nbusy = 0, first_v = -1, last_v = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboards as the DUT issues pairs and completes runs.
  always @(negedge clk) begin
    if (reset) begin
      if (mac_valid) begin
        nvalid = nvalid + 1;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        n_checks = n_checks + 1;
        if (pair_q.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL pair_unexpected got a=%0d b=%0d required none", $signed(mac_a), $signed(mac_b));
        end else begin
          pair_t e;
          e = pair_q.pop_front();
          if (mac_a !== e.a || mac_b !== e.b) begin
            n_fail = n_fail + 1;
            $display("FAIL pair got a=%0d b=%0d required a=%0d b=%0d",
                     $signed(mac_a), $signed(mac_b), $signed(e.a), $signed(e.b));
          end
        end
      end
      if (mac_rst) nrst = nrst + 1;
      if (busy) nbusy = nbusy + 1;
      if (done) begin
        n_checks = n_checks + 1;
        if (res_q.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL done_unexpected got result=%0d required no done", $signed(result));
        end else begin
          res_t r;
          r = res_q.pop_front();
          if (result !== r.res || error !== r.err) begin
            n_fail = n_fail + 1;
            $display("FAIL result got %0d err=%0b required %0d err=%0b",
                     $signed(result), error, $signed(r.res), r.err);
          end
        end
      end
    end
  end

  task automatic load_buffers();
    for (int k = 0; k < VLEN; k++) begin
      @(posedge clk); #1;
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'(k); wr_data = mdl_a[k];
      @(posedge clk); #1;
      wr_sel = 1'b1; wr_data = mdl_b[k];
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic set_vec(input int a0, a1, a2, a3, b0, b1, b2, b3);
    mdl_a[0] = W'(a0); mdl_a[1] = W'(a1); mdl_a[2] = W'(a2); mdl_a[3] = W'(a3);
    mdl_b[0] = W'(b0); mdl_b[1] = W'(b1); mdl_b[2] = W'(b2); mdl_b[3] = W'(b3);
  endtask

  task automatic run_vec(input string name, input int exp_res, input bit exp_err,
                         input int exp_busy, input int exp_span,
                         input logic [7:0] pmask, input bit poke);
    bit got;
    int nissued;
    for (int k = 0; k < VLEN; k++) pair_q.push_back({mdl_a[k], mdl_b[k]});
    res_q.push_back({OW'(exp_res), exp_err});
    nvalid = 0; nrst = 0; nbusy = 0; first_v = -1; last_v = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mac_rst !== 1'b1 || error !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_clear got rst=%0b err=%0b busy=%0b required 1 0 1", name, mac_rst, error, busy);
    end
    nissued = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      pause   = pmask[c];
      wr_en   = poke && (c == 1);
      wr_sel  = 1'b0;
      wr_addr = 2'd3;
      wr_data = W'(100);
      start   = poke && (c == 5);
      @(negedge clk);
      if (pmask[c] && nissued > 0) begin
        n_checks++;
        if (mac_valid !== 1'b0 || mac_a !== mdl_a[nissued-1] || mac_b !== mdl_b[nissued-1]) begin
          n_fail++;
          $display("FAIL %s_hold got v=%0b a=%0d b=%0d required v=0 a=%0d b=%0d", name,
                   mac_valid, $signed(mac_a), $signed(mac_b), mdl_a[nissued-1], mdl_b[nissued-1]);
        end
      end
      if (!pmask[c]) nissued++;
    end
    pause = 1'b0; wr_en = 1'b0; start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_timeout got no done required done within 100 cycles", name);
    end
    n_checks++;
    if (nvalid != VLEN || nrst != 1 || nbusy != exp_busy || (last_v - first_v + 1) != exp_span) begin
      n_fail++;
      $display("FAIL %s_shape got valid=%0d rst=%0d busy=%0d span=%0d required %0d 1 %0d %0d",
               name, nvalid, nrst, nbusy, last_v - first_v + 1, VLEN, exp_busy, exp_span);
    end
    $display("run %s: result=%0d error=%0b busy_cycles=%0d", name, $signed(result), error, nbusy);
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({mac_rst, mac_valid, busy, done, error} !== 5'b0 || mac_a !== '0 || mac_b !== '0 || result !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got rst=%0b v=%0b busy=%0b done=%0b err=%0b a=%0d b=%0d res=%0d required all 0",
               mac_rst, mac_valid, busy, done, error, mac_a, mac_b, result);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle got busy=%0b done=%0b required 0 0", busy, done);
    end
    $display("reset released");
  endtask

  task automatic test_basic();
    set_vec(1, 2, 3, 4, 5, 6, 7, 8);
    load_buffers();
    run_vec("basic", 70, 1'b0, 8, 4, 8'h00, 1'b0);
  endtask

  task automatic test_signed();
    set_vec(-3, 2, 0, -1, 4, -5, 9, -7);
    load_buffers();
    run_vec("signed", -15, 1'b0, 8, 4, 8'h00, 1'b0);
  endtask

  task automatic test_saturate();
    set_vec(8191, 8191, 8191, 8191, 8191, 8191, 8191, 8191);
    load_buffers();
    run_vec("saturate", 134217727, 1'b0, 8, 4, 8'h00, 1'b0);
  endtask

  task automatic test_pause();
    set_vec(1, 2, 3, 4, 5, 6, 7, 8);
    load_buffers();
    run_vec("pause", 70, 1'b0, 10, 6, 8'b0000_1100, 1'b0);
  endtask

  task automatic test_timeout();
    mac_conn = 1'b0;
    run_vec("timeout", 70, 1'b1, 1 + VLEN + TO, 4, 8'h00, 1'b0);
    mac_conn = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL error_hold got err=%0b busy=%0b required 1 0", error, busy);
    end
  endtask

  task automatic test_back_to_back();
    run_vec("b2b_first", 70, 1'b0, 8, 4, 8'h00, 1'b1);
    run_vec("b2b_second", 70, 1'b0, 8, 4, 8'h00, 1'b0);
    repeat (25) @(negedge clk);
    n_checks++;
    if (res_q.size() != 0 || pair_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_quiet got res_q=%0d pair_q=%0d busy=%0b required 0 0 0",
               res_q.size(), pair_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    set_vec(1, 2, 3, 4, 5, 6, 7, 8);
    load_buffers();
    for (int k = 0; k < VLEN; k++) pair_q.push_back({mdl_a[k], mdl_b[k]});
    nvalid = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (nvalid >= 2) seen = 1'b1;
    end
    n_checks++;
    if (!seen || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_reach got valid=%0d busy=%0b required >=2 1", nvalid, busy);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({mac_rst, mac_valid, busy, done, error} !== 5'b0 || mac_a !== '0 || mac_b !== '0 || result !== '0) begin
      n_fail++;
      $display("FAIL midrun_async got rst=%0b v=%0b busy=%0b done=%0b err=%0b a=%0d b=%0d res=%0d required all 0",
               mac_rst, mac_valid, busy, done, error, mac_a, mac_b, result);
    end
    pair_q.delete();
    res_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    $display("reset released after mid-run abort");
    set_vec(-3, 2, 0, -1, 4, -5, 9, -7);
    load_buffers();
    run_vec("after_reset", -15, 1'b0, 8, 4, 8'h00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_saturate();
    test_pause();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
